// File: rtl/regfile_wb_queue_pkg.sv
// Shared types for the RegFile writeback queue: register geometry and the
// queued entry layout.
package regfile_wb_queue_pkg;

    localparam int AW = 5;
    localparam int DW = 32;

    localparam logic [AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wbq_entry_t;

endpackage

// File: rtl/regfile_wb_queue_wbq_fifo.sv
// In-order storage for pending writebacks. Besides the head it exposes every
// slot in age order (index 0 = oldest) so the top can run a bypass search.
module wbq_fifo
    import regfile_wb_queue_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  wbq_entry_t       i_push_entry,
    input  logic             i_pop,
    output wbq_entry_t       o_head,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty,
    output wbq_entry_t       o_entries [DEPTH],
    output logic [DEPTH-1:0] o_valid
);

    wbq_entry_t        r_mem [DEPTH];
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_push) begin
                r_mem[r_tail] <= i_push_entry;
                r_tail        <= r_tail + PW'(1);
            end
            if (i_pop) begin
                r_head <= r_head + PW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_head];
    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);

    // Pointers wrap naturally because DEPTH is a power of two.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_age
            logic [PW-1:0] w_idx;
            assign w_idx         = r_head + PW'(gi);
            assign o_entries[gi] = r_mem[w_idx];
            assign o_valid[gi]   = (CW'(gi) < r_count);
        end
    endgenerate

endmodule

// File: rtl/regfile_wb_queue.sv
// Writeback front end for the 2R/1W RegFile: arbitrates ALU/load requests,
// queues them in order, drives one RegFile write per cycle and forwards
// pending data to the decode read ports.
module regfile_wb_queue
    import regfile_wb_queue_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          alu_valid,
    output logic          alu_ready,
    input  logic [AW-1:0] alu_wa,
    input  logic [DW-1:0] alu_wd,
    input  logic          mem_valid,
    output logic          mem_ready,
    input  logic [AW-1:0] mem_wa,
    input  logic [DW-1:0] mem_wd,
    input  logic          drain_en,
    output logic          we,
    output logic [AW-1:0] wa,
    output logic [DW-1:0] wd,
    input  logic [AW-1:0] lk_ra1,
    input  logic [AW-1:0] lk_ra2,
    output logic          lk_hit1,
    output logic          lk_hit2,
    output logic [DW-1:0] lk_data1,
    output logic [DW-1:0] lk_data2,
    output logic [CW-1:0] count
);

    wbq_entry_t       w_head;
    wbq_entry_t       w_in_entry;
    wbq_entry_t       w_entries [DEPTH];
    logic [DEPTH-1:0] w_valid;
    logic             w_full;
    logic             w_empty;
    logic             w_mem_hs;
    logic             w_alu_hs;
    logic             w_push;
    logic             w_pop;
    logic [AW-1:0]    w_lk_ra [2];

    // Load returns win arbitration; full is taken before any same-cycle pop.
    assign mem_ready = !w_full;
    assign alu_ready = !w_full && !mem_valid;
    assign w_mem_hs  = mem_valid && mem_ready;
    assign w_alu_hs  = alu_valid && alu_ready;

    always_comb begin
        w_in_entry = '0;
        if (w_mem_hs) begin
            w_in_entry.addr = mem_wa;
            w_in_entry.data = mem_wd;
        end else begin
            w_in_entry.addr = alu_wa;
            w_in_entry.data = alu_wd;
        end
    end

    // Writes to r0 finish the handshake but never occupy a slot.
    assign w_push = (w_mem_hs || w_alu_hs) && (w_in_entry.addr != REG_ZERO);
    assign w_pop  = drain_en && !w_empty;

    wbq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (w_push),
        .i_push_entry (w_in_entry),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_count      (count),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_entries    (w_entries),
        .o_valid      (w_valid)
    );

    assign we = w_pop;
    assign wa = w_empty ? '0 : w_head.addr;
    assign wd = w_empty ? '0 : w_head.data;

    assign w_lk_ra[0] = lk_ra1;
    assign w_lk_ra[1] = lk_ra2;

    // Scan oldest to youngest so the youngest match is the one left standing;
    // the head being written this cycle is still forwarded.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lookup
            logic          w_hit;
            logic [DW-1:0] w_data;
            always_comb begin
                w_hit  = 1'b0;
                w_data = '0;
                for (int k = 0; k < DEPTH; k++) begin
                    if (w_valid[k] && (w_lk_ra[gi] != REG_ZERO) &&
                        (w_entries[k].addr == w_lk_ra[gi])) begin
                        w_hit  = 1'b1;
                        w_data = w_entries[k].data;
                    end
                end
            end
        end
    endgenerate

    assign lk_hit1  = g_lookup[0].w_hit;
    assign lk_data1 = g_lookup[0].w_data;
    assign lk_hit2  = g_lookup[1].w_hit;
    assign lk_data2 = g_lookup[1].w_data;

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Scoreboard bench for regfile_wb_queue: accepted requests are queued as
// expected RegFile writes and compared when the DUT asserts we.
module tb_regfile_wb_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    logic          clk;
    logic          rst_n;
    logic          alu_valid, alu_ready, mem_valid, mem_ready, drain_en;
    logic [4:0]    alu_wa, mem_wa, wa, lk_ra1, lk_ra2;
    logic [31:0]   alu_wd, mem_wd, wd, lk_data1, lk_data2;
    logic          we, lk_hit1, lk_hit2;
    logic [CW-1:0] count;

    int            n_checks;
    int            n_fail;
    ent_t          pend_q [$];
    logic [31:0]   rf [32];
    logic [4:0]    wr_log [$];
    int            wr_cnt;

    regfile_wb_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_wa    (alu_wa),
        .alu_wd    (alu_wd),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_wa    (mem_wa),
        .mem_wd    (mem_wd),
        .drain_en  (drain_en),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .lk_ra1    (lk_ra1),
        .lk_ra2    (lk_ra2),
        .lk_hit1   (lk_hit1),
        .lk_hit2   (lk_hit2),
        .lk_data1  (lk_data1),
        .lk_data2  (lk_data2),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RegFile sink: records every write the DUT issues.
    always @(posedge clk) begin
        if (we) begin
            rf[wa] <= wd;
            wr_log.push_back(wa);
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_lookup(input logic [4:0] ra, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
        if (ra != 5'd0) begin
            for (int i = 0; i < pend_q.size(); i++) begin
                if (pend_q[i].a == ra) begin
                    hit = 1'b1;
                    d   = pend_q[i].d;
                end
            end
        end
    endfunction

    // One clock cycle: apply inputs, check every output against the model,
    // advance the model, then step past the next rising edge.
    task automatic drive_cycle(input string tag,
                               input logic mv, input logic [4:0] mwa, input logic [31:0] mwd,
                               input logic av, input logic [4:0] awa, input logic [31:0] awd,
                               input logic de, input logic [4:0] ra1, input logic [4:0] ra2,
                               output logic acc_mem, output logic acc_alu);
        logic        e_full, e_mr, e_ar, e_we, e_h1, e_h2;
        logic [31:0] e_d1, e_d2;
        ent_t        head;
        mem_valid = mv; mem_wa = mwa; mem_wd = mwd;
        alu_valid = av; alu_wa = awa; alu_wd = awd;
        drain_en = de; lk_ra1 = ra1; lk_ra2 = ra2;
        #1;
        e_full = (pend_q.size() >= DEPTH);
        e_mr   = !e_full;
        e_ar   = !e_full && !mv;
        e_we   = de && (pend_q.size() > 0);
        head   = (pend_q.size() > 0) ? pend_q[0] : '0;
        model_lookup(ra1, e_h1, e_d1);
        model_lookup(ra2, e_h2, e_d2);
        check_eq({tag, "_mem_ready"}, 64'(mem_ready), 64'(e_mr));
        check_eq({tag, "_alu_ready"}, 64'(alu_ready), 64'(e_ar));
        check_eq({tag, "_count"}, 64'(count), 64'(pend_q.size()));
        check_eq({tag, "_we"}, 64'(we), 64'(e_we));
        check_eq({tag, "_wa"}, 64'(wa), 64'(head.a));
        check_eq({tag, "_wd"}, 64'(wd), 64'(head.d));
        check_eq({tag, "_hit1"}, 64'(lk_hit1), 64'(e_h1));
        check_eq({tag, "_data1"}, 64'(lk_data1), 64'(e_d1));
        check_eq({tag, "_hit2"}, 64'(lk_hit2), 64'(e_h2));
        check_eq({tag, "_data2"}, 64'(lk_data2), 64'(e_d2));
        if (we) begin
            if (pend_q.size() == 0) begin
                check_eq({tag, "_spurious_we"}, 64'(we), 64'(0));
            end else begin
                head = pend_q.pop_front();
                $display("txn %s write r%0d=%0h", tag, head.a, head.d);
            end
        end
        acc_mem = mv && e_mr;
        acc_alu = av && e_ar;
        if (acc_mem) begin
            $display("txn %s accept mem r%0d=%0h", tag, mwa, mwd);
            if (mwa != 5'd0) pend_q.push_back('{a: mwa, d: mwd});
        end else if (acc_alu) begin
            $display("txn %s accept alu r%0d=%0h", tag, awa, awd);
            if (awa != 5'd0) pend_q.push_back('{a: awa, d: awd});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag, input logic de, input logic [4:0] ra1, input logic [4:0] ra2);
        logic am, aa;
        drive_cycle(tag, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, de, ra1, ra2, am, aa);
    endtask

    initial begin
        #5000;
        $display("FAIL watchdog: got timeout expected finish");
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic am, aa;
        int   base, wc;
        n_checks = 0; n_fail = 0; wr_cnt = 0;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        rst_n = 1'b0;
        alu_valid = 0; alu_wa = 0; alu_wd = 0;
        mem_valid = 0; mem_wa = 0; mem_wd = 0;
        drain_en = 0; lk_ra1 = 5'd2; lk_ra2 = 5'd0;

        #12;
        check_eq("rst_we", 64'(we), 64'(0));
        check_eq("rst_count", 64'(count), 64'(0));
        check_eq("rst_wa", 64'(wa), 64'(0));
        check_eq("rst_wd", 64'(wd), 64'(0));
        check_eq("rst_hit1", 64'(lk_hit1), 64'(0));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single ALU write, earliest possible drain.
        drive_cycle("t1", 0, 0, 0, 1, 5'd2, 32'd94, 1, 5'd2, 5'd0, am, aa);
        check_eq("t1_accept", 64'(aa), 64'(1));
        idle("t1d", 1, 5'd2, 5'd0);
        check_eq("t1_rf2", 64'(rf[2]), 64'd94);

        // Simultaneous requests: load first, ALU next cycle, writes in order.
        base = wr_log.size();
        drive_cycle("t2a", 1, 5'd3, 32'd7, 1, 5'd4, 32'd8, 0, 5'd3, 5'd4, am, aa);
        check_eq("t2_mem_acc", 64'(am), 64'(1));
        check_eq("t2_alu_blocked", 64'(aa), 64'(0));
        drive_cycle("t2b", 0, 0, 0, 1, 5'd4, 32'd8, 0, 5'd3, 5'd4, am, aa);
        check_eq("t2_alu_acc", 64'(aa), 64'(1));
        for (int i = 0; i < 3; i++) idle("t2d", 1, 5'd3, 5'd4);
        check_eq("t2_order0", 64'(wr_log[base]), 64'd3);
        check_eq("t2_order1", 64'(wr_log[base + 1]), 64'd4);

        // Fill to DEPTH with drain off; fifth request waits for space.
        for (int i = 0; i < 5; i++) begin
            drive_cycle("t3f", 0, 0, 0, 1, 5'(8 + i), 32'(100 + i), 0, 5'd9, 5'd11, am, aa);
            check_eq("t3_fill_acc", 64'(aa), 64'(i < 4));
        end
        check_eq("t3_count_full", 64'(count), 64'd4);
        aa = 1'b0;
        for (int i = 0; i < 8 && !aa; i++) begin
            drive_cycle("t3w", 0, 0, 0, 1, 5'd12, 32'd104, 1, 5'd12, 5'd8, am, aa);
        end
        check_eq("t3_late_acc", 64'(aa), 64'(1));
        for (int i = 0; i < 6; i++) idle("t3d", 1, 5'd12, 5'd0);

        // Same register twice: youngest forwarded, last value lands.
        drive_cycle("t4a", 0, 0, 0, 1, 5'd6, 32'd11, 0, 5'd6, 5'd0, am, aa);
        drive_cycle("t4b", 0, 0, 0, 1, 5'd6, 32'd22, 0, 5'd6, 5'd0, am, aa);
        idle("t4c", 0, 5'd6, 5'd6);
        check_eq("t4_hit1", 64'(lk_hit1), 64'(1));
        check_eq("t4_data1", 64'(lk_data1), 64'd22);
        for (int i = 0; i < 3; i++) idle("t4d", 1, 5'd6, 5'd0);
        check_eq("t4_rf6", 64'(rf[6]), 64'd22);

        // r0 writes handshake but are dropped.
        wc = wr_cnt;
        drive_cycle("t5a", 0, 0, 0, 1, 5'd0, 32'd13, 1, 5'd0, 5'd0, am, aa);
        check_eq("t5_accept", 64'(aa), 64'(1));
        idle("t5b", 1, 5'd0, 5'd0);
        check_eq("t5_no_write", 64'(wr_cnt), 64'(wc));

        // Reset in the middle of a drain.
        drive_cycle("t6a", 0, 0, 0, 1, 5'd20, 32'd1, 0, 5'd21, 5'd0, am, aa);
        drive_cycle("t6b", 0, 0, 0, 1, 5'd21, 32'd2, 0, 5'd21, 5'd0, am, aa);
        drive_cycle("t6c", 1, 5'd22, 32'd3, 0, 0, 0, 0, 5'd21, 5'd0, am, aa);
        idle("t6d", 1, 5'd21, 5'd0);
        drain_en = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        pend_q.delete();
        check_eq("t6_rst_we", 64'(we), 64'(0));
        check_eq("t6_rst_count", 64'(count), 64'(0));
        check_eq("t6_rst_hit1", 64'(lk_hit1), 64'(0));
        wc = wr_cnt;
        repeat (3) @(posedge clk);
        #1;
        check_eq("t6_no_write_in_rst", 64'(wr_cnt), 64'(wc));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle("t6e", 1, 5'd21, 5'd22);
        idle("t6f", 1, 5'd20, 5'd0);
        check_eq("t6_no_write_after", 64'(wr_cnt), 64'(wc));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
